// File: rtl/sdram_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares one SDRAM controller request interface (16-bit word address, 32-bit
// data, req/ack/valid handshake) between a CPU port (port 0) and a video/DMA
// port (port 1). One transaction is latched at a time and driven to the
// controller. The ack, valid and read data are routed back to the port that
// owns the transaction. A read watchdog raises a sticky err flag when the
// controller never returns read data.
//
// Build option:
//   SDRAM_ARB_FIXED_PRIORITY_EN  defined   -> port 0 always wins a tie
//                                undefined -> round-robin on a tie (default)
//
// All outputs are registered. There is no combinational path from the
// requester inputs to the controller outputs.
// ----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_cpu,
    input  logic        reset,
    // port 0 (CPU)
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [31:0] p0_din,
    output logic        p0_ack,
    output logic        p0_valid,
    // port 1 (video/DMA)
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [31:0] p1_din,
    output logic        p1_ack,
    output logic        p1_valid,
    // shared read data
    output logic [31:0] rd_data,
    // SDRAM controller side
    output logic        sd_req,
    output logic        sd_we,
    output logic [15:0] sd_addr,
    output logic [31:0] sd_data,
    input  logic        sd_ack,
    input  logic        sd_valid,
    input  logic [31:0] sd_q,
    // sticky read-timeout flag
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    // Last value of the watchdog counter before the read is abandoned, so
    // that err rises exactly TIMEOUT cycles after WAIT_RD is entered.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;

    logic        grant_s;
    logic        ack_s;
    logic        valid_s;
    logic        timeout_s;
    logic        win_s;

    logic        owner_r;
    logic        sd_req_r;
    logic        sd_we_r;
    logic [15:0] sd_addr_r;
    logic [31:0] sd_data_r;
    logic [31:0] rd_data_r;
    logic        p0_ack_r;
    logic        p1_ack_r;
    logic        p0_valid_r;
    logic        p1_valid_r;
    logic        err_r;

`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
    logic        last_r;

    // Round-robin pointer: remembers the most recent owner, moves only on grant.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (grant_s) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    // Winner selection among the currently requesting ports.
    always_comb begin
        win_s = 1'b0;
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
        if (p0_req) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`else
        if (p0_req && p1_req) begin
            win_s = ~last_r;
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and per-cycle event strobes for the datapath.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        grant_s   = 1'b0;
        ack_s     = 1'b0;
        valid_s   = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    grant_s = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (sd_ack) begin
                    ack_s = 1'b1;
                    if (sd_we_r) begin
                        state_s = ST_IDLE;
                    end else if (sd_valid) begin
                        // data returned together with the ack
                        valid_s = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s   = 8'd0;
                        state_s = ST_WAIT_RD;
                    end
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT_RD: begin
                if (sd_valid) begin
                    valid_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                    state_s = ST_WAIT_RD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Watchdog counter register.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

    // Transaction latch towards the controller and ownership record.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            sd_req_r  <= 1'b0;
            sd_we_r   <= 1'b0;
            sd_addr_r <= 16'h0000;
            sd_data_r <= 32'h0000_0000;
            owner_r   <= 1'b0;
        end else if (grant_s) begin
            sd_req_r  <= 1'b1;
            sd_we_r   <= win_s ? p1_we   : p0_we;
            sd_addr_r <= win_s ? p1_addr : p0_addr;
            sd_data_r <= win_s ? p1_din  : p0_din;
            owner_r   <= win_s;
        end else if (ack_s) begin
            sd_req_r  <= 1'b0;
        end else begin
            sd_req_r  <= sd_req_r;
        end
    end

    // Ack and valid pulses routed to the owning port; pulses last one cycle.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            p0_ack_r   <= 1'b0;
            p1_ack_r   <= 1'b0;
            p0_valid_r <= 1'b0;
            p1_valid_r <= 1'b0;
        end else begin
            p0_ack_r   <= ack_s   & ~owner_r;
            p1_ack_r   <= ack_s   &  owner_r;
            p0_valid_r <= valid_s & ~owner_r;
            p1_valid_r <= valid_s &  owner_r;
        end
    end

    // Shared read data register; holds until the next completed read.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            rd_data_r <= 32'h0000_0000;
        end else if (valid_s) begin
            rd_data_r <= sd_q;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    // Sticky read-timeout flag, cleared only by reset.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign sd_req   = sd_req_r;
    assign sd_we    = sd_we_r;
    assign sd_addr  = sd_addr_r;
    assign sd_data  = sd_data_r;
    assign rd_data  = rd_data_r;
    assign p0_ack   = p0_ack_r;
    assign p1_ack   = p1_ack_r;
    assign p0_valid = p0_valid_r;
    assign p1_valid = p1_valid_r;
    assign err      = err_r;

endmodule
